// File: rtl/gumnut_fetch_unit.sv
// Gumnut instruction-fetch front end.
// A Wishbone-classic fetch master keeps a small prefetch FIFO topped up with
// {pc, instruction} pairs. Redirects flush the FIFO; a fetch that is still in
// flight when a redirect arrives is allowed to finish on the bus (DRAIN) and
// its data is thrown away.
module gumnut_fetch_unit #(
    parameter int              AW         = 12,
    parameter int              IW         = 18,
    parameter int              DEPTH      = 4,
    parameter logic [AW-1:0]   RESET_ADDR = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clkEn_i,
    output logic                     inst_cyc_o,
    output logic                     inst_stb_o,
    output logic [AW-1:0]            inst_addr_o,
    input  logic [IW-1:0]            inst_dat_i,
    input  logic                     inst_ack_i,
    input  logic                     pc_load_i,
    input  logic [AW-1:0]            pc_target_i,
    output logic                     inst_valid_o,
    output logic [IW-1:0]            inst_o,
    output logic [AW-1:0]            inst_pc_o,
    input  logic                     inst_ready_i,
    output logic [$clog2(DEPTH):0]   fifo_level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,   // no bus cycle open
        ST_REQ,    // bus cycle open, data will be kept
        ST_DRAIN   // bus cycle open for a request made before a redirect
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_stb;
    logic [AW-1:0]        r_addr;
    logic [AW-1:0]        w_addr_next;
    logic [AW-1:0]        r_fetch_pc;
    logic [AW-1:0]        w_fetch_pc_next;

    logic [AW+IW-1:0]     r_mem [DEPTH];
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        w_count_next;

    logic                 w_ack;
    logic                 w_flush;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_space;

    // Bus handshake and FIFO bookkeeping for this cycle.
    always_comb begin
        w_ack   = r_stb & inst_ack_i;
        w_flush = pc_load_i;
        w_push  = (r_state == ST_REQ) & w_ack & ~pc_load_i;
        // A pop that coincides with a flush has no effect of its own.
        w_pop   = inst_ready_i & (r_count != '0) & ~w_flush;
        if (w_flush) begin
            w_count_next = '0;
        end else begin
            w_count_next = r_count + CW'(w_push) - CW'(w_pop);
        end
        w_space = (w_count_next < FULL_LVL);
    end

    // Fetch FSM next-state and next request address.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        w_state_next    = r_state;
        w_addr_next     = r_addr;
        w_fetch_pc_next = r_fetch_pc;
        unique case (r_state)
            ST_IDLE: begin
                if (pc_load_i) begin
                    w_fetch_pc_next = pc_target_i;
                    w_addr_next     = pc_target_i;
                    w_state_next    = ST_REQ;
                end else if (w_space) begin
                    w_addr_next  = r_fetch_pc;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_ack && !pc_load_i) begin
                    w_fetch_pc_next = r_addr + AW'(1);
                    if (w_space) begin
                        w_addr_next = r_addr + AW'(1);
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (w_ack && pc_load_i) begin
                    // Returned word belongs to the old stream: drop it and
                    // start the new stream on the very next bus cycle.
                    w_fetch_pc_next = pc_target_i;
                    w_addr_next     = pc_target_i;
                end else if (pc_load_i) begin
                    // Wishbone cycles are never aborted; wait for the ack.
                    w_fetch_pc_next = pc_target_i;
                    w_state_next    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pc_load_i) begin
                    w_fetch_pc_next = pc_target_i;
                end
                if (w_ack) begin
                    w_addr_next  = pc_load_i ? pc_target_i : r_fetch_pc;
                    w_state_next = ST_REQ;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Fetch FSM state, strobe and address registers.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_stb      <= 1'b0;
            r_addr     <= RESET_ADDR;
            r_fetch_pc <= RESET_ADDR;
        end else if (clkEn_i) begin
            r_state    <= w_state_next;
            r_stb      <= (w_state_next != ST_IDLE);
            r_addr     <= w_addr_next;
            r_fetch_pc <= w_fetch_pc_next;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clkEn_i) begin
            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
            end
            r_count <= w_count_next;
        end
    end

    // FIFO storage: write the acknowledged word at the tail.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array has no reset; entries are only read while
        // the count says they hold data, so only pointers and count reset.
        if (clkEn_i && w_push) begin
            r_mem[r_wr_ptr] <= {r_addr, inst_dat_i};
        end
    end

    assign inst_cyc_o              = r_stb;
    assign inst_stb_o              = r_stb;
    assign inst_addr_o             = r_addr;
    assign {inst_pc_o, inst_o}     = r_mem[r_rd_ptr];
    assign inst_valid_o            = (r_count != '0);
    assign fifo_level_o            = r_count;

endmodule

// File: tb/tb_gumnut_fetch_unit.sv
// Self-checking bench for gumnut_fetch_unit: a behavioural Wishbone slave with
// configurable ack latency, a scoreboard of expected fetch addresses, and a
// second instance with RESET_ADDR near the top of the address space.
module tb_gumnut_fetch_unit;

    localparam int AW    = 12;
    localparam int IW    = 18;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clk_en;
    logic          cyc, stb, ack, pc_load, valid, ready;
    logic [AW-1:0] addr, target, inst_pc;
    logic [IW-1:0] dat, inst;
    logic [LW-1:0] level;

    logic          cyc2, stb2, ack2, pc_load2, valid2, ready2;
    logic [AW-1:0] addr2, target2, inst_pc2;
    logic [IW-1:0] dat2, inst2;
    logic [LW-1:0] level2;

    gumnut_fetch_unit #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_ADDR(12'h000)) dut (
        .clk_i(clk), .rst_i(rst), .clkEn_i(clk_en),
        .inst_cyc_o(cyc), .inst_stb_o(stb), .inst_addr_o(addr),
        .inst_dat_i(dat), .inst_ack_i(ack),
        .pc_load_i(pc_load), .pc_target_i(target),
        .inst_valid_o(valid), .inst_o(inst), .inst_pc_o(inst_pc),
        .inst_ready_i(ready), .fifo_level_o(level)
    );

    gumnut_fetch_unit #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_ADDR(12'hFFE)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .clkEn_i(clk_en),
        .inst_cyc_o(cyc2), .inst_stb_o(stb2), .inst_addr_o(addr2),
        .inst_dat_i(dat2), .inst_ack_i(ack2),
        .pc_load_i(pc_load2), .pc_target_i(target2),
        .inst_valid_o(valid2), .inst_o(inst2), .inst_pc_o(inst_pc2),
        .inst_ready_i(ready2), .fifo_level_o(level2)
    );

    typedef struct {
        logic          had_exp;
        logic [AW-1:0] exp_pc;
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } pair_t;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] iss_q[$];
    int            iss_cyc_q[$];
    pair_t         pair_q[$];
    logic [AW-1:0] iss2_q[$];
    logic [AW-1:0] pop2_pc_q[$];
    logic [IW-1:0] pop2_inst_q[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;
    int   sl_cnt = 0;
    int   slave_lat = 0;
    int   max_level = 0;
    logic m_drain = 1'b0;

    function automatic logic [IW-1:0] mk_dat(input logic [AW-1:0] a);
        return {6'h2B, a};
    endfunction

    // One clock cycle: score what the current inputs will do at the coming
    // edge, take the edge, then let the slaves answer the new bus state.
    task automatic step();
        logic  en_now, acc, stb_before;
        pair_t p;
        en_now     = clk_en && !rst;
        stb_before = stb;
        acc        = en_now && stb && ack;
        if (en_now) begin
            if (valid && ready && !pc_load) begin
                p.had_exp = (exp_q.size() != 0);
                p.exp_pc  = '0;
                if (p.had_exp) p.exp_pc = exp_q.pop_front();
                p.pc   = inst_pc;
                p.inst = inst;
                pair_q.push_back(p);
            end
            if (pc_load) begin
                exp_q.delete();
                m_drain = stb && !ack;
            end else if (acc) begin
                if (m_drain) m_drain = 1'b0;
                else         exp_q.push_back(addr);
            end
            if (acc) begin
                iss_q.push_back(addr);
                iss_cyc_q.push_back(cyc_n);
            end
            if (stb2 && ack2) iss2_q.push_back(addr2);
            if (valid2 && ready2) begin
                pop2_pc_q.push_back(inst_pc2);
                pop2_inst_q.push_back(inst2);
            end
        end
        @(posedge clk);
        cyc_n++;
        #1;
        if (acc) sl_cnt = 0;
        else if (stb_before === 1'b1) sl_cnt++;
        if (stb === 1'b1) begin
            ack = (sl_cnt >= slave_lat);
        end else begin
            ack    = 1'b0;
            sl_cnt = 0;
        end
        dat  = mk_dat(addr);
        ack2 = (stb2 === 1'b1);
        dat2 = mk_dat(addr2);
        if (int'(level) > max_level) max_level = int'(level);
    endtask

    task automatic do_reset();
        rst = 1'b1; clk_en = 1'b1; pc_load = 1'b0; ready = 1'b0; ready2 = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete(); iss_q.delete(); iss_cyc_q.delete(); pair_q.delete();
        iss2_q.delete(); pop2_pc_q.delete(); pop2_inst_q.delete();
        m_drain = 1'b0; max_level = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b1; pc_load = 1'b0; target = '0; ready = 1'b0;
        ack = 1'b0; dat = '0; ready2 = 1'b0; slave_lat = 5;
        step();
        step();
        total++;
        if ({stb, cyc, valid, level} !== {1'b0, 1'b0, 1'b0, 3'd0}) begin
            bad++; $display("FAIL reset_ctrl: got stb=%b cyc=%b valid=%b level=%0d want 0 0 0 0",
                            stb, cyc, valid, level);
        end
        total++;
        if (addr !== 12'h000 || addr2 !== 12'hFFE || stb2 !== 1'b0) begin
            bad++; $display("FAIL reset_addr: got %h/%h stb2=%b want 000/ffe 0", addr, addr2, stb2);
        end
        rst = 1'b0;
        step();
        total++;
        if (stb !== 1'b1 || cyc !== 1'b1 || addr !== 12'h000) begin
            bad++; $display("FAIL first_req: got stb=%b cyc=%b addr=%h want 1 1 000", stb, cyc, addr);
        end
        rst = 1'b1;
        step();
        total++;
        if (stb !== 1'b0) begin
            bad++; $display("FAIL reset_open_cycle: got stb=%b want 0", stb);
        end
        ack = 1'b1;  // late ack arriving after the reset
        rst = 1'b0;
        step();
        total++;
        if (level !== 3'd0 || stb !== 1'b1 || addr !== 12'h000) begin
            bad++; $display("FAIL late_ack: got level=%0d stb=%b addr=%h want 0 1 000", level, stb, addr);
        end
    endtask

    task automatic test_fill();
        slave_lat = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (iss_q.size() >= 4 && !stb) break;
            step();
        end
        total++;
        if (iss_q.size() != 4 || stb !== 1'b0) begin
            bad++; $display("FAIL fill_done: got issued=%0d stb=%b want 4 0", iss_q.size(), stb);
        end
        for (int k = 0; k < 4 && k < iss_q.size(); k++) begin
            total++;
            if (iss_q[k] !== AW'(k) || iss_cyc_q[k] - iss_cyc_q[0] != k) begin
                bad++; $display("FAIL fill_addr%0d: got addr=%h dcyc=%0d want %h %0d",
                                k, iss_q[k], iss_cyc_q[k] - iss_cyc_q[0], AW'(k), k);
            end
        end
        step();
        step();
        total++;
        if (level !== 3'd4 || stb !== 1'b0 || valid !== 1'b1) begin
            bad++; $display("FAIL fill_full: got level=%0d stb=%b valid=%b want 4 0 1", level, stb, valid);
        end
        total++;
        if (inst_pc !== 12'h000 || inst !== mk_dat(12'h000)) begin
            bad++; $display("FAIL fill_head: got pc=%h inst=%h want 000 %h", inst_pc, inst, mk_dat(12'h000));
        end
    endtask

    task automatic test_back_to_back();
        ready = 1'b1;
        pair_q.delete();
        for (int i = 0; i < 30; i++) step();
        total++;
        if (pair_q.size() != 30) begin
            bad++; $display("FAIL stream_rate: got pops=%0d want 30", pair_q.size());
        end
        for (int k = 0; k < pair_q.size(); k++) begin
            total++;
            if (!pair_q[k].had_exp || pair_q[k].pc !== pair_q[k].exp_pc || pair_q[k].pc !== AW'(k)
                || pair_q[k].inst !== mk_dat(AW'(k))) begin
                bad++; $display("FAIL stream_pop%0d: got pc=%h inst=%h sb=%h want pc=%h inst=%h",
                                k, pair_q[k].pc, pair_q[k].inst, pair_q[k].exp_pc, AW'(k), mk_dat(AW'(k)));
            end
        end
        total++;
        if (max_level > DEPTH) begin
            bad++; $display("FAIL stream_level: got max=%0d want <=%0d", max_level, DEPTH);
        end
        ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        int n;
        slave_lat = 3;
        do_reset();
        ready = 1'b1;
        step();
        total++;
        if (stb !== 1'b1 || addr !== 12'h000) begin
            bad++; $display("FAIL wait_req: got stb=%b addr=%h want 1 000", stb, addr);
        end
        pc_load = 1'b1; target = 12'h100;
        step();
        pc_load = 1'b0;
        n = 0;
        while (addr !== 12'h100 && n < 10) begin
            total++;
            if (stb !== 1'b1 || addr !== 12'h000 || level !== 3'd0) begin
                bad++; $display("FAIL drain_hold: got stb=%b addr=%h level=%0d want 1 000 0", stb, addr, level);
            end
            step();
            n++;
        end
        total++;
        if (stb !== 1'b1 || addr !== 12'h100) begin
            bad++; $display("FAIL drain_next: got stb=%b addr=%h want 1 100", stb, addr);
        end
        for (int i = 0; i < 15; i++) step();
        total++;
        if (pair_q.size() < 2) begin
            bad++; $display("FAIL redirect_pops: got pops=%0d want >=2", pair_q.size());
        end
        for (int k = 0; k < pair_q.size(); k++) begin
            total++;
            if (!pair_q[k].had_exp || pair_q[k].pc !== pair_q[k].exp_pc
                || pair_q[k].pc !== 12'h100 + AW'(k) || pair_q[k].inst !== mk_dat(12'h100 + AW'(k))) begin
                bad++; $display("FAIL redirect_pop%0d: got pc=%h inst=%h want pc=%h", k,
                                pair_q[k].pc, pair_q[k].inst, 12'h100 + AW'(k));
            end
        end
        ready = 1'b0;
    endtask

    task automatic test_redirect_ack();
        slave_lat = 0;
        do_reset();
        step();
        step();
        step();
        total++;
        if (level !== 3'd2 || addr !== 12'h002 || ack !== 1'b1) begin
            bad++; $display("FAIL pre_load: got level=%0d addr=%h ack=%b want 2 002 1", level, addr, ack);
        end
        pair_q.delete();
        pc_load = 1'b1; target = 12'h040; ready = 1'b1;
        step();
        pc_load = 1'b0; ready = 1'b0;
        total++;
        if (level !== 3'd0 || valid !== 1'b0 || stb !== 1'b1 || addr !== 12'h040) begin
            bad++; $display("FAIL load_on_ack: got level=%0d valid=%b stb=%b addr=%h want 0 0 1 040",
                            level, valid, stb, addr);
        end
        ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        total++;
        if (pair_q.size() != 7) begin
            bad++; $display("FAIL load_ack_pops: got pops=%0d want 7", pair_q.size());
        end
        for (int k = 0; k < pair_q.size(); k++) begin
            total++;
            if (!pair_q[k].had_exp || pair_q[k].pc !== pair_q[k].exp_pc || pair_q[k].pc !== 12'h040 + AW'(k)) begin
                bad++; $display("FAIL load_ack_pop%0d: got pc=%h want %h", k, pair_q[k].pc, 12'h040 + AW'(k));
            end
        end
        ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] e;
        slave_lat = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (iss2_q.size() >= 4 && !stb2) break;
            step();
        end
        total++;
        if (iss2_q.size() != 4 || stb2 !== 1'b0 || level2 !== 3'd4) begin
            bad++; $display("FAIL wrap_fill: got issued=%0d stb=%b level=%0d want 4 0 4",
                            iss2_q.size(), stb2, level2);
        end
        for (int k = 0; k < iss2_q.size(); k++) begin
            e = 12'hFFE + AW'(k);
            total++;
            if (iss2_q[k] !== e) begin
                bad++; $display("FAIL wrap_addr%0d: got %h want %h", k, iss2_q[k], e);
            end
        end
        ready2 = 1'b1;
        for (int i = 0; i < 8; i++) step();
        ready2 = 1'b0;
        total++;
        if (pop2_pc_q.size() != 8) begin
            bad++; $display("FAIL wrap_pops: got pops=%0d want 8", pop2_pc_q.size());
        end
        for (int k = 0; k < pop2_pc_q.size(); k++) begin
            e = 12'hFFE + AW'(k);
            total++;
            if (pop2_pc_q[k] !== e || pop2_inst_q[k] !== mk_dat(e)) begin
                bad++; $display("FAIL wrap_pop%0d: got pc=%h inst=%h want %h %h",
                                k, pop2_pc_q[k], pop2_inst_q[k], e, mk_dat(e));
            end
        end
    endtask

    task automatic test_clk_en();
        slave_lat = 0;
        do_reset();
        step();
        step();
        step();
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (level !== 3'd2 || addr !== 12'h002 || stb !== 1'b1 || valid !== 1'b1
                || inst_pc !== 12'h000 || ack !== 1'b1) begin
                bad++; $display("FAIL frozen%0d: got level=%0d addr=%h stb=%b valid=%b pc=%h ack=%b want 2 002 1 1 000 1",
                                i, level, addr, stb, valid, inst_pc, ack);
            end
        end
        clk_en = 1'b1;
        step();
        total++;
        if (level !== 3'd3 || addr !== 12'h003) begin
            bad++; $display("FAIL reenable: got level=%0d addr=%h want 3 003", level, addr);
        end
        for (int i = 0; i < 10; i++) begin
            if (!stb) break;
            step();
        end
        total++;
        if (level !== 3'd4 || stb !== 1'b0 || iss_q.size() != 4) begin
            bad++; $display("FAIL en_fill: got level=%0d stb=%b issued=%0d want 4 0 4", level, stb, iss_q.size());
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= pair_q.size()) begin
                bad++; $display("FAIL en_pop%0d: got none want pc=%h", k, AW'(k));
            end else if (!pair_q[k].had_exp || pair_q[k].pc !== pair_q[k].exp_pc || pair_q[k].pc !== AW'(k)) begin
                bad++; $display("FAIL en_pop%0d: got pc=%h want %h", k, pair_q[k].pc, AW'(k));
            end
        end
    endtask

    initial begin
        pc_load2 = 1'b0; target2 = '0; ack2 = 1'b0; dat2 = '0;
        test_reset();
        test_fill();
        test_back_to_back();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap();
        test_clk_en();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule

// File: doc/gumnut_fetch_unit.md
Name: gumnut_fetch_unit

Overview:
Parametrised instruction-fetch front end for the Gumnut core family. It replaces the bare PC-to-bus path of the first-generation core with a Wishbone-classic fetch master and a DEPTH-entry prefetch FIFO. Redirects (jump, branch, return, interrupt vector) flush the FIFO and discard any fetch still in flight. It sits between the instruction memory bus and the control/processing units, which consume {pc, instruction} pairs through a valid/ready port.

Parameters:
AW, 12, instruction address width
IW, 18, instruction word width
DEPTH, 4, prefetch FIFO entries; power of two, >= 2
RESET_ADDR, 0, fetch address after reset (AW bits)

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous, active-high reset
clkEn_i  input  1  clock enable; low = every register holds, outputs hold
inst_cyc_o  output  1  Wishbone cycle; always equal to inst_stb_o
inst_stb_o  output  1  Wishbone strobe, registered
inst_addr_o  output  AW  fetch address, registered, stable while stb high
inst_dat_i  input  IW  fetched instruction word
inst_ack_i  input  1  bus acknowledge; sampled only while stb high
pc_load_i  input  1  redirect request from control unit
pc_target_i  input  AW  redirect target address
inst_valid_o  output  1  FIFO head valid
inst_o  output  IW  FIFO head instruction
inst_pc_o  output  AW  address of inst_o
inst_ready_i  input  1  consumer takes head when valid & ready
fifo_level_o  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_i=1 at an edge; this overrides clkEn_i): state=IDLE; stb/cyc=0; FIFO empty; inst_valid_o=0; fifo_level_o=0; inst_addr_o=RESET_ADDR; fetch_pc=RESET_ADDR. Reset during an open bus cycle drops stb immediately; a late ack is ignored.
- Internal fetch_pc = next address to request. Increment is modulo 2^AW, so 2^AW-1 wraps to 0.
- Space condition: space = (count_next < DEPTH), where count_next is the occupancy after this cycle's push/pop. Only one request is ever outstanding, so the FIFO can never overflow.
- State IDLE (stb=0):
  - pc_load_i: flush FIFO; fetch_pc<=target; go to REQ with addr=target.
  - Else if space: go to REQ with addr=fetch_pc.
- State REQ (stb=1, addr held):
  - ack and no pc_load: push {addr, inst_dat_i}; fetch_pc<=addr+1. If space after the push, stay in REQ with addr=addr+1 (back-to-back, one word per cycle with a zero-wait slave). Otherwise go to IDLE.
  - ack and pc_load: discard data; flush; fetch_pc<=target; stay in REQ with addr=target.
  - pc_load and no ack: flush; fetch_pc<=target; go to DRAIN. stb and addr hold; the Wishbone cycle is not aborted.
  - Neither: hold.
- State DRAIN (stb=1, old addr held):
  - On ack: discard data; go to REQ with addr=fetch_pc.
  - Further pc_load: flush (FIFO is already empty); fetch_pc<=latest target; stay in DRAIN.
- Consumer side:
  - inst_o/inst_pc_o/inst_valid_o come from the head register.
  - An ack in cycle N becomes visible at N+1.
  - A pop and a push in the same cycle leave the count unchanged.
  - pop when empty: ignored.
  - pop in the same cycle as pc_load_i: flush wins; the pop has no extra effect.
- clkEn_i=0: no state change. stb/addr stay asserted and acks in that cycle are ignored, so the slave must hold ack until an enabled cycle. This is a system-level rule, and the Gumnut bus slaves are already gated by the same enable.
- Synthesisable FIFO: circular buffer with log2(DEPTH)-bit read/write pointers and separate count. No FIFO data reset is needed; only the pointers and count reset.

Test Plan:
- Reset, then zero-wait slave (ack whenever stb) returning data=addr, inst_ready_i=0 -> addresses 0,1,2,3 issued on consecutive cycles; stb drops after the 4th ack; fifo_level_o=4; head shows inst_pc_o=0, inst_o=0.
- Continue with inst_ready_i=1 -> pairs pop in order 0,1,2,3,4,…, one per cycle in steady state; the level never exceeds 4; no word is skipped or duplicated.
- Slave with 3-cycle ack latency; pc_load_i=1, target=0x100 one cycle after stb rises -> old address held until its ack; data discarded; next request addr=0x100; first popped inst_pc_o=0x100.
- pc_load_i (target 0x040) in the same cycle as an ack -> that word is never seen at the output; the next stb cycle uses addr 0x040; FIFO empty the following cycle.
- RESET_ADDR=0xFFE, zero-wait slave -> issued addresses 0xFFE, 0xFFF, 0x000, 0x001; popped inst_pc_o follows the same wrap.
- clkEn_i low for 5 cycles mid-stream with the slave holding ack -> outputs frozen, fifo_level_o constant; on re-enable exactly one push occurs per held ack.
